// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default sizes, active
// levels, and the write-hit lookup used by both the bypass mux and the scoreboard.
package rf_pkg;

  localparam int unsigned RF_XLEN = 64;
  localparam int unsigned RF_NREG = 32;
  localparam int unsigned MAX_NW  = 8;
  localparam int unsigned MAX_AW  = 8;
  localparam int unsigned HIT_IW  = $clog2(MAX_NW);

  localparam logic [RF_XLEN-1:0] RF_ZERO = '0;

  localparam logic RD_EN_ACT = 1'b1;
  localparam logic WR_EN_ACT = 1'b1;
  localparam logic RST_ACT   = 1'b0;

  typedef struct packed {
    logic              hit;
    logic [HIT_IW-1:0] idx;
  } wr_hit_t;

  // Later ports overwrite earlier matches, so the highest-index writer wins.
  function automatic wr_hit_t wr_hit(input logic [MAX_NW-1:0]             en,
                                     input logic [MAX_NW-1:0][MAX_AW-1:0] addrs,
                                     input logic [MAX_AW-1:0]             addr);
    wr_hit_t r;
    r = '0;
    for (int unsigned i = 0; i < MAX_NW; i++) begin
      if (en[i] == WR_EN_ACT && addrs[i] == addr) begin
        r.hit = 1'b1;
        r.idx = HIT_IW'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write busy bits: flush beats issue, issue beats write-back clear.
// rd_busy is a combinational lookup, masked when the producer is being forwarded.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int unsigned NREG = RF_NREG,
  parameter  int unsigned NR   = 2,
  parameter  int unsigned NW   = 1,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             flush,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NR-1:0]    rd_en,
  input  logic [NR*AW-1:0] rd_addr,
  input  logic [NR-1:0]    rd_fwd,
  output logic [NR-1:0]    rd_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      for (int unsigned i = 0; i < NW; i++) begin
        if (wr_en[i] == WR_EN_ACT) busy_nxt[wr_addr[i*AW +: AW]] = 1'b0;
      end
      if (iss_en && iss_addr != '0) busy_nxt[iss_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (rstn == RST_ACT) busy <= '0;
    else                 busy <= busy_nxt;
  end

  always_comb begin
    rd_busy = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      rd_busy[i] = busy[rd_addr[i*AW +: AW]] && (rd_en[i] == RD_EN_ACT) && !rd_fwd[i];
    end
  end

endmodule

// File: rtl/rf_mp_scoreboard.sv
// Parametrised multi-port integer register file with optional registered reads,
// same-cycle write bypass and a pending-write scoreboard for ID hazard checks.
module rf_mp_scoreboard
  import rf_pkg::*;
#(
  parameter  int unsigned XLEN     = RF_XLEN,
  parameter  int unsigned NREG     = RF_NREG,
  parameter  int unsigned NR       = 2,
  parameter  int unsigned NW       = 1,
  parameter  int unsigned READ_LAT = 0,
  parameter  int unsigned BYPASS   = 1,
  localparam int unsigned AW       = $clog2(NREG)
) (
  input  logic               sys_clk,
  input  logic               rstn,
  input  logic [NR-1:0]      rd_en,
  input  logic [NR*AW-1:0]   rd_addr,
  output logic [NR*XLEN-1:0] rd_data,
  output logic [NR-1:0]      rd_busy,
  input  logic [NW-1:0]      wr_en,
  input  logic [NW*AW-1:0]   wr_addr,
  input  logic [NW*XLEN-1:0] wr_data,
  input  logic               iss_en,
  input  logic [AW-1:0]      iss_addr,
  input  logic               flush,
  input  logic [AW-1:0]      dbg_addr,
  output logic [XLEN-1:0]    dbg_data
);

  localparam logic [XLEN-1:0] ZERO = XLEN'(RF_ZERO);

  logic [XLEN-1:0]               regs [NREG];
  logic [MAX_NW-1:0]             wen_ext;
  logic [MAX_NW-1:0][MAX_AW-1:0] wa_ext;
  logic [NR-1:0][XLEN-1:0]       rd_comb;
  logic [NR-1:0][XLEN-1:0]       rd_commit;
  logic [NR-1:0]                 rd_fwd;

  // Widen the write ports to the package's fixed lookup shape; x0 writes never hit.
  always_comb begin
    wen_ext = '0;
    wa_ext  = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      wen_ext[i] = (wr_en[i] == WR_EN_ACT) && (wr_addr[i*AW +: AW] != '0);
      wa_ext[i]  = MAX_AW'(wr_addr[i*AW +: AW]);
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (rstn == RST_ACT) begin
      for (int unsigned r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int unsigned i = 0; i < NW; i++) begin
        if (wen_ext[i]) regs[wa_ext[i][AW-1:0]] <= wr_data[i*XLEN +: XLEN];
      end
    end
  end

  assign dbg_data = regs[dbg_addr];

  for (genvar g = 0; g < NR; g++) begin : g_rd
    logic [AW-1:0]   a;
    wr_hit_t         h;
    logic [XLEN-1:0] fwd_val;

    assign a       = rd_addr[g*AW +: AW];
    assign h       = wr_hit(wen_ext, wa_ext, MAX_AW'(a));
    assign fwd_val = wr_data[int'(h.idx)*XLEN +: XLEN];
    assign rd_fwd[g]    = (BYPASS != 0) && h.hit;
    assign rd_comb[g]   = (a == '0) ? ZERO : (rd_fwd[g] ? fwd_val : regs[a]);
    // The registered path always sees the write landing on the same edge.
    assign rd_commit[g] = (a == '0) ? ZERO : (h.hit ? fwd_val : regs[a]);
  end

  if (READ_LAT != 0) begin : g_lat1
    logic [NR*XLEN-1:0] rd_q;

    always_ff @(posedge sys_clk or negedge rstn) begin
      if (rstn == RST_ACT) begin
        rd_q <= '0;
      end else begin
        for (int unsigned i = 0; i < NR; i++) begin
          if (rd_en[i] == RD_EN_ACT) rd_q[i*XLEN +: XLEN] <= rd_commit[i];
        end
      end
    end

    assign rd_data = rd_q;
  end else begin : g_lat0
    always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < NR; i++) begin
        rd_data[i*XLEN +: XLEN] = (rd_en[i] == RD_EN_ACT) ? rd_comb[i] : ZERO;
      end
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .NR   (NR),
    .NW   (NW)
  ) u_sb (
    .sys_clk  (sys_clk),
    .rstn     (rstn),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_fwd   (rd_fwd),
    .rd_busy  (rd_busy)
  );

endmodule
